pc_link_stack: RTL and testbench

PC_LINK_STACK -- requirements
Module: pc_link_stack

---
 rtl/pc_link_stack.sv | 136 +++++++++++++
 tb/tb_pc_link_stack.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_link_stack.sv
// pc_link_stack: computes the link value for each valid instruction and
// keeps a circular return-address stack. OP_CALL pushes PC+1 and OP_JUMPR
// pops the most recent entry. count, overflow and underflow report stack state.
module pc_link_stack #(
   parameter int PC_WIDTH  = 12,
   parameter int OP_WIDTH  = 6,
   parameter int DEPTH     = 8,
   parameter int WRAP_MODE = 1,
   parameter logic [OP_WIDTH-1:0] OP_JUMP    = 6'b010101,
   parameter logic [OP_WIDTH-1:0] OP_JUMPR   = 6'b100011,
   parameter logic [OP_WIDTH-1:0] OP_PBRANCH = 6'b011111,
   parameter logic [OP_WIDTH-1:0] OP_BRANCHZ = 6'b010011,
   parameter logic [OP_WIDTH-1:0] OP_BRANCHN = 6'b010100,
   parameter logic [OP_WIDTH-1:0] OP_CALL    = 6'b010111
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       valid_in,
   input  logic [PC_WIDTH-1:0]        program_counter,
   input  logic [OP_WIDTH-1:0]        operation,
   input  logic                       flush,
   output logic [PC_WIDTH-1:0]        link_pc,
   output logic                       link_valid,
   output logic [PC_WIDTH-1:0]        return_pc,
   output logic                       return_valid,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty,
   output logic                       full,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PC_WIDTH-1:0] r_stack [DEPTH];
   logic [PW-1:0]       r_top;        // next slot to write; top entry is r_top-1
   logic [CW-1:0]       r_count;
   logic [PC_WIDTH-1:0] r_link_pc;
   logic                r_link_valid;
   logic [PC_WIDTH-1:0] r_return_pc;
   logic                r_return_valid;
   logic                r_overflow;
   logic                r_underflow;

   logic [PC_WIDTH-1:0] w_link;
   logic                w_accept;
   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_empty;
   logic                w_push_write;
   logic                w_pop_ok;
   logic [PW-1:0]       w_rd_idx;

   // Link value selection; arithmetic wraps naturally at PC_WIDTH bits
   always_comb begin
      w_link = program_counter + PC_WIDTH'(1);
      if (operation == OP_JUMP || operation == OP_JUMPR || operation == OP_PBRANCH)
         w_link = program_counter;
      else if (operation == OP_BRANCHZ || operation == OP_BRANCHN)
         w_link = program_counter - PC_WIDTH'(1);
   end

   // Flush dominates any valid instruction in the same cycle
   assign w_accept     = valid_in & ~flush;
   assign w_push       = w_accept & (operation == OP_CALL);
   assign w_pop        = w_accept & (operation == OP_JUMPR);
   assign w_full       = (r_count == CW'(DEPTH));
   assign w_empty      = (r_count == '0);
   // A full push only lands in storage when overwriting the oldest entry is allowed
   assign w_push_write = w_push & (~w_full | (WRAP_MODE != 0));
   assign w_pop_ok     = w_pop & ~w_empty;
   assign w_rd_idx     = r_top - PW'(1);

   // Entry storage: no reset, contents are never observable while empty
   always_ff @(posedge clock) begin
      if (w_push_write)
         r_stack[r_top] <= w_link;
   end

   // Output registers, pointer, count and sticky error flags
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_top          <= '0;
         r_count        <= '0;
         r_link_pc      <= '0;
         r_link_valid   <= 1'b0;
         r_return_pc    <= '0;
         r_return_valid <= 1'b0;
         r_overflow     <= 1'b0;
         r_underflow    <= 1'b0;
      end else begin
         r_link_valid   <= w_accept;
         r_return_valid <= w_pop_ok;
         if (w_accept)
            r_link_pc <= w_link;
         if (w_pop_ok)
            r_return_pc <= r_stack[w_rd_idx];

         if (flush) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else if (w_push) begin
            if (w_full)
               r_overflow <= 1'b1;
            else
               r_count <= r_count + CW'(1);
            // When full and wrapping, the write slot equals the oldest entry,
            // so advancing the pointer keeps count at DEPTH
            if (w_push_write)
               r_top <= r_top + PW'(1);
         end else if (w_pop) begin
            if (w_empty) begin
               r_underflow <= 1'b1;
            end else begin
               r_count <= r_count - CW'(1);
               r_top   <= w_rd_idx;
            end
         end
      end
   end

   assign link_pc      = r_link_pc;
   assign link_valid   = r_link_valid;
   assign return_pc    = r_return_pc;
   assign return_valid = r_return_valid;
   assign count        = r_count;
   assign empty        = w_empty;
   assign full         = w_full;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_pc_link_stack.sv
// Bench for pc_link_stack: two instances (wrap and drop full-stack policies)
// share stimulus; a reference stack model predicts outputs into per-instance
// queues that a monitor drains and compares on the falling clock edge.
module tb_pc_link_stack;

   localparam logic [5:0] OP_JUMP    = 6'b010101;
   localparam logic [5:0] OP_JUMPR   = 6'b100011;
   localparam logic [5:0] OP_PBRANCH = 6'b011111;
   localparam logic [5:0] OP_BRANCHZ = 6'b010011;
   localparam logic [5:0] OP_BRANCHN = 6'b010100;
   localparam logic [5:0] OP_CALL    = 6'b010111;
   localparam int         DEPTH      = 8;

   typedef struct {
      logic        lv;
      logic [11:0] lpc;
      logic        rv;
      logic [11:0] rpc;
      int          cnt;
      logic        ov;
      logic        un;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        valid_in;
   logic [11:0] program_counter;
   logic [5:0]  operation;
   logic        flush;

   logic [11:0] link_pc[2];
   logic        link_valid[2];
   logic [11:0] return_pc[2];
   logic        return_valid[2];
   logic [3:0]  count[2];
   logic        empty[2];
   logic        full[2];
   logic        overflow[2];
   logic        underflow[2];

   int n_vec = 0;
   int n_err = 0;

   exp_t q0[$];
   exp_t q1[$];

   // Reference model state: index 0 = wrap policy, 1 = drop policy
   logic [11:0] m_stk[2][DEPTH];
   int          m_n[2];
   logic [11:0] m_lpc[2];
   logic [11:0] m_rpc[2];
   logic        m_ov[2];
   logic        m_un[2];

   always #5 clock = ~clock;

   pc_link_stack #(.WRAP_MODE(1)) u_wrap (
      .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
      .program_counter(program_counter), .operation(operation), .flush(flush),
      .link_pc(link_pc[0]), .link_valid(link_valid[0]),
      .return_pc(return_pc[0]), .return_valid(return_valid[0]),
      .count(count[0]), .empty(empty[0]), .full(full[0]),
      .overflow(overflow[0]), .underflow(underflow[0]));

   pc_link_stack #(.WRAP_MODE(0)) u_drop (
      .clock(clock), .reset_n(reset_n), .valid_in(valid_in),
      .program_counter(program_counter), .operation(operation), .flush(flush),
      .link_pc(link_pc[1]), .link_valid(link_valid[1]),
      .return_pc(return_pc[1]), .return_valid(return_valid[1]),
      .count(count[1]), .empty(empty[1]), .full(full[1]),
      .overflow(overflow[1]), .underflow(underflow[1]));

   function automatic logic [11:0] f_link(input logic [5:0] op, input logic [11:0] pc);
      if (op == OP_JUMP || op == OP_JUMPR || op == OP_PBRANCH) return pc;
      if (op == OP_BRANCHZ || op == OP_BRANCHN) return pc - 12'd1;
      return pc + 12'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_inst(input int w, input exp_t e);
      string p;
      p = (w == 0) ? "wrap" : "drop";
      chk({p, ".link_valid"},   32'(link_valid[w]),   32'(e.lv));
      chk({p, ".link_pc"},      32'(link_pc[w]),      32'(e.lpc));
      chk({p, ".return_valid"}, 32'(return_valid[w]), 32'(e.rv));
      chk({p, ".return_pc"},    32'(return_pc[w]),    32'(e.rpc));
      chk({p, ".count"},        32'(count[w]),        32'(e.cnt));
      chk({p, ".empty"},        32'(empty[w]),        32'(e.cnt == 0));
      chk({p, ".full"},         32'(full[w]),         32'(e.cnt == DEPTH));
      chk({p, ".overflow"},     32'(overflow[w]),     32'(e.ov));
      chk({p, ".underflow"},    32'(underflow[w]),    32'(e.un));
   endtask

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         m_n[w] = 0; m_lpc[w] = '0; m_rpc[w] = '0; m_ov[w] = 1'b0; m_un[w] = 1'b0;
      end
   endtask

   // Outputs must be at reset values without any clock edge
   task automatic rst_check(input string tag);
      exp_t e;
      e = '{lv: 1'b0, lpc: 12'h0, rv: 1'b0, rpc: 12'h0, cnt: 0, ov: 1'b0, un: 1'b0};
      $display("%s: checking reset outputs", tag);
      chk_inst(0, e);
      chk_inst(1, e);
   endtask

   // Apply one cycle of stimulus; expected results are queued after the edge
   task automatic step(input logic v, input logic [5:0] op, input logic [11:0] pc, input logic fl);
      exp_t e[2];
      valid_in = v; operation = op; program_counter = pc; flush = fl;
      for (int w = 0; w < 2; w++) begin
         e[w].lv = v && !fl;
         e[w].rv = 1'b0;
         if (e[w].lv) m_lpc[w] = f_link(op, pc);
         if (fl) begin
            m_n[w] = 0; m_ov[w] = 1'b0; m_un[w] = 1'b0;
         end else if (v && op == OP_CALL) begin
            if (m_n[w] < DEPTH) begin
               m_stk[w][m_n[w]] = pc + 12'd1;
               m_n[w]++;
            end else begin
               m_ov[w] = 1'b1;
               if (w == 0) begin
                  for (int k = 0; k < DEPTH - 1; k++) m_stk[w][k] = m_stk[w][k+1];
                  m_stk[w][DEPTH-1] = pc + 12'd1;
               end
            end
         end else if (v && op == OP_JUMPR) begin
            if (m_n[w] == 0) begin
               m_un[w] = 1'b1;
            end else begin
               m_n[w]--;
               m_rpc[w] = m_stk[w][m_n[w]];
               e[w].rv = 1'b1;
            end
         end
         e[w].lpc = m_lpc[w];
         e[w].rpc = m_rpc[w];
         e[w].cnt = m_n[w];
         e[w].ov  = m_ov[w];
         e[w].un  = m_un[w];
      end
      $display("step v=%0b op=%b pc=%h flush=%0b -> wrap(lv=%0b lpc=%h rv=%0b rpc=%h cnt=%0d) drop(rv=%0b rpc=%h cnt=%0d)",
               v, op, pc, fl, e[0].lv, e[0].lpc, e[0].rv, e[0].rpc, e[0].cnt, e[1].rv, e[1].rpc, e[1].cnt);
      @(posedge clock);
      q0.push_back(e[0]);
      q1.push_back(e[1]);
      #1;
   endtask

   // Monitor: compare queued predictions once the DUT has presented them
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (q0.size() > 0) begin e = q0.pop_front(); chk_inst(0, e); end
         if (q1.size() > 0) begin e = q1.pop_front(); chk_inst(1, e); end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] ops[8];
      ops = '{OP_JUMP, OP_JUMPR, OP_PBRANCH, OP_BRANCHZ, OP_BRANCHN, OP_CALL, 6'b000000, 6'b111111};
      reset_n = 1'b0; valid_in = 1'b0; operation = '0; program_counter = '0; flush = 1'b0;
      model_reset();
      #1 rst_check("init_reset");
      repeat (2) @(posedge clock);
      #3 reset_n = 1'b1;
      @(posedge clock); #1;

      // Link rules including wrap-around
      step(1, OP_JUMP,    12'h010, 0);
      step(1, OP_BRANCHZ, 12'h010, 0);
      step(1, 6'b000000,  12'h010, 0);
      step(0, OP_JUMP,    12'h555, 0);
      step(1, 6'b000000,  12'hFFF, 0);
      step(1, OP_BRANCHN, 12'h000, 0);

      // LIFO order
      step(1, OP_CALL, 12'h100, 0);
      step(1, OP_CALL, 12'h200, 0);
      step(1, OP_CALL, 12'h300, 0);
      step(1, OP_JUMPR, 12'h400, 0);
      step(1, OP_JUMPR, 12'h401, 0);
      step(1, OP_JUMPR, 12'h402, 0);

      // Underflow, sticky until flush
      step(1, OP_JUMPR, 12'h500, 0);
      step(1, OP_JUMP,  12'h501, 0);
      step(1, OP_CALL,  12'h502, 0);
      step(0, 6'b0,     12'h0,   1);

      // Full stack: nine calls, eight pops, one extra pop
      for (int i = 0; i < 9; i++) step(1, OP_CALL, 12'(i), 0);
      for (int i = 0; i < 9; i++) step(1, OP_JUMPR, 12'h7F0, 0);
      step(0, 6'b0, 12'h0, 1);

      // Flush beats a valid call
      step(1, OP_CALL, 12'h0AA, 0);
      step(1, OP_CALL, 12'h0BB, 1);
      step(1, OP_JUMPR, 12'h0CC, 0);

      // Asynchronous reset in the middle of a push sequence
      step(1, OP_CALL, 12'h123, 0);
      valid_in = 1'b1; operation = OP_CALL; program_counter = 12'h456;
      @(negedge clock); #2;
      reset_n = 1'b0;
      model_reset();
      #1 rst_check("mid_reset");
      @(posedge clock); #2;
      valid_in = 1'b0;
      reset_n = 1'b1;
      @(posedge clock); #1;
      step(1, OP_JUMPR, 12'h333, 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         int r;
         logic v;
         logic [5:0] op;
         r = $urandom_range(0, 99);
         v = ($urandom_range(0, 9) != 0);
         if (r < 35)      op = OP_CALL;
         else if (r < 60) op = OP_JUMPR;
         else             op = ops[$urandom_range(0, 7)];
         step(v, op, 12'($urandom), ($urandom_range(0, 99) < 5));
      end

      valid_in = 1'b0; flush = 1'b0;
      for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clock);
      #1;
      chk("queue_drained", 32'(q0.size() + q1.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
